// File: rtl/fp_expand_serial_if.sv
// fp_expand_serial_if: start/busy/done handshake and S/E/F -> Q data bundle for fp_expand_serial.
interface fp_expand_serial_if #(
    parameter int EW = 3,
    parameter int FW = 4,
    parameter int QW = 12
);
    logic          start;
    logic          S;
    logic [EW-1:0] E;
    logic [FW-1:0] F;
    logic          busy;
    logic          done;
    logic [QW-1:0] Q;
    modport master(output start, S, E, F, input busy, done, Q);
    modport slave(input start, S, E, F, output busy, done, Q);
endinterface

// File: rtl/fp_expand_serial.sv
// fp_expand_serial: rebuilds Q = (-1)^S * F * 2^E as two's complement, one left shift per clock.
module fp_expand_serial #(
    parameter int EW = 3,
    parameter int FW = 4,
    parameter int QW = 12
) (
    input logic clk,
    input logic rst,
    fp_expand_serial_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state, state_n;
    logic [QW-1:0] acc, acc_n, q, q_n;
    logic [EW-1:0] cnt, cnt_n;
    logic          sgn, sgn_n, busy, busy_n, done, done_n;
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        sgn_n   = sgn;
        q_n     = q;
        busy_n  = busy;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                acc_n   = QW'(bus.F);
                cnt_n   = bus.E;
                sgn_n   = bus.S;
                busy_n  = 1'b1;
                state_n = SHIFT;
            end
        end else if (cnt != '0) begin
            acc_n = acc << 1;
            cnt_n = cnt - EW'(1);
        end else begin
            // negating zero wraps back to zero, so S=1,F=0 needs no special case
            q_n     = sgn ? ~acc + QW'(1) : acc;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            sgn   <= sgn_n;
            q     <= q_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.Q    = q;
endmodule
